// File: rtl/mux_alu_src_if.sv
// Operand-B selector bus: source operands and control in, selected operand
// (combinational and registered) out.
interface mux_alu_src_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] readData2;
  logic [WIDTH-1:0] imm;
  logic             ALUsrc;
  logic             in_valid;
  logic             hold;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_q;
  logic             b_valid;
  logic             sel_q;

  modport master (
    output readData2, imm, ALUsrc, in_valid, hold,
    input  b, b_q, b_valid, sel_q
  );

  modport slave (
    input  readData2, imm, ALUsrc, in_valid, hold,
    output b, b_q, b_valid, sel_q
  );
endinterface

// File: rtl/mux_alu_src.sv
// ALU operand-B source mux: zero-latency select of readData2/imm plus a
// registered copy with valid flag and stall hold for pipelined datapaths.
module mux_alu_src #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mux_alu_src_if.slave  bus
);

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] b_reg;
  logic             sel_reg;
  logic             valid_reg;

  always_comb begin
    b_sel = bus.ALUsrc ? bus.imm : bus.readData2;
  end

  // Data and select are only loaded on a capture; an idle cycle drops the
  // valid flag but leaves the last operand visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_reg     <= '0;
      sel_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (!bus.hold) begin
      if (bus.in_valid) begin
        b_reg   <= b_sel;
        sel_reg <= bus.ALUsrc;
      end
      valid_reg <= bus.in_valid;
    end
  end

  assign bus.b       = b_sel;
  assign bus.b_q     = b_reg;
  assign bus.sel_q   = sel_reg;
  assign bus.b_valid = valid_reg;

endmodule

// File: tb/tb_mux_alu_src.sv
// Directed bench for mux_alu_src: combinational select, capture, hold
// priority, idle behaviour and asynchronous reset.
module tb_mux_alu_src;

  logic clk;
  logic rst_n;
  int unsigned n_vec;
  int unsigned n_bad;

  mux_alu_src_if #(.WIDTH(32)) bus ();

  mux_alu_src #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] rd2, input logic [31:0] im, input logic sel);
    bus.readData2 = rd2;
    bus.imm       = im;
    bus.ALUsrc    = sel;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    drive(32'd0, 32'd0, 1'b0);

    check("rst_b_q",     bus.b_q,     32'h0);
    check("rst_b_valid", {31'b0, bus.b_valid}, 32'h0);
    check("rst_sel_q",   {31'b0, bus.sel_q},   32'h0);

    // Combinational path, exercised while reset is still asserted
    drive(32'd4, 32'd0, 1'b0);            check("reg_4",       bus.b, 32'd4);
    drive(32'd5, 32'd0, 1'b0);            check("reg_5",       bus.b, 32'd5);
    drive(32'd2, 32'd1, 1'b1);            check("imm_1",       bus.b, 32'd1);
    drive(32'd1, 32'd1, 1'b0);            check("overlap_reg", bus.b, 32'd1);
    drive(32'd0, 32'd0, 1'b1);            check("imm_0_a",     bus.b, 32'd0);
    drive(32'd1, 32'd0, 1'b1);            check("imm_0_b",     bus.b, 32'd0);
    drive(32'd0, 32'd17, 1'b1);           check("imm_17",      bus.b, 32'd17);
    drive(32'd1, 32'd9, 1'b1);            check("imm_9",       bus.b, 32'd9);
    drive(32'h0, 32'hFFFF_FFFF, 1'b1);    check("imm_full",    bus.b, 32'hFFFF_FFFF);
    drive(32'hA5A5_5A5A, 32'h0, 1'b0);    check("reg_full",    bus.b, 32'hA5A5_5A5A);

    // Clock edges during reset must not capture
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_b_q", bus.b_q, 32'h0);
    check("rst_hold_vld", {31'b0, bus.b_valid}, 32'h0);

    // Release, first capture
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h1234, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("cap_b_q",   bus.b_q, 32'h1234);
    check("cap_sel_q", {31'b0, bus.sel_q},   32'h0);
    check("cap_valid", {31'b0, bus.b_valid}, 32'h1);

    // Idle cycle: valid drops, data stays
    @(negedge clk);
    bus.in_valid = 1'b0;
    drive(32'h9999, 32'h7777, 1'b1);
    @(posedge clk); #1;
    check("idle_valid", {31'b0, bus.b_valid}, 32'h0);
    check("idle_b_q",   bus.b_q, 32'h1234);
    check("idle_sel_q", {31'b0, bus.sel_q}, 32'h0);

    // Recapture 0x1234, then hold for three edges with a different operand
    @(negedge clk);
    bus.in_valid = 1'b1;
    drive(32'h1234, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("recap_valid", {31'b0, bus.b_valid}, 32'h1);
    @(negedge clk);
    bus.hold = 1'b1;
    drive(32'h0, 32'hABCD, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_b_q",   bus.b_q, 32'h1234);
      check("hold_valid", {31'b0, bus.b_valid}, 32'h1);
    end
    check("hold_sel_q", {31'b0, bus.sel_q}, 32'h0);
    check("hold_b",     bus.b, 32'hABCD);

    @(negedge clk);
    bus.hold = 1'b0;
    @(posedge clk); #1;
    check("unhold_b_q",  bus.b_q, 32'hABCD);
    check("unhold_sel",  {31'b0, bus.sel_q}, 32'h1);
    check("unhold_vld",  {31'b0, bus.b_valid}, 32'h1);

    // Hold with in_valid low must also keep b_valid high
    @(negedge clk);
    bus.hold = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_idle_vld", {31'b0, bus.b_valid}, 32'h1);

    // Back-to-back captures
    @(negedge clk);
    bus.hold = 1'b0;
    bus.in_valid = 1'b1;
    drive(32'h0000_0011, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("b2b_0", bus.b_q, 32'h11);
    drive(32'h0, 32'h0000_0022, 1'b1);
    @(posedge clk); #1;
    check("b2b_1", bus.b_q, 32'h22);
    check("b2b_1_sel", {31'b0, bus.sel_q}, 32'h1);
    drive(32'h0000_0033, 32'h44, 1'b0);
    @(posedge clk); #1;
    check("b2b_2", bus.b_q, 32'h33);
    check("b2b_2_sel", {31'b0, bus.sel_q}, 32'h0);

    // Recapture 0xABCD then assert reset between edges
    drive(32'h0, 32'hABCD, 1'b1);
    @(posedge clk); #2;
    check("pre_rst_b_q", bus.b_q, 32'hABCD);
    rst_n = 1'b0;
    #1;
    check("async_b_q",   bus.b_q, 32'h0);
    check("async_valid", {31'b0, bus.b_valid}, 32'h0);
    check("async_sel_q", {31'b0, bus.sel_q},   32'h0);
    drive(32'h5555, 32'hABCD, 1'b0);
    check("async_b", bus.b, 32'h5555);
    @(posedge clk); #1;
    check("async_stay", bus.b_q, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
